rv32_exec_datapath: RTL and testbench

RV32I integer execution datapath: a 32×32-bit register file with two combinational read ports and one synchronous write port, feeding a combinational ALU. The ALU's A operand is always read port 1. The B operand, the opcode and the write-back data are supplied by the CPU control logic. It sits between instruction decode and the write-back multiplexer of the single-cycle core.

---
 rtl/rv32_pkg.sv | 28 ++
 rtl/rv32_exec_datapath_if.sv | 38 +++
 rtl/rv32_alu.sv | 52 +++++
 rtl/rv32_exec_datapath.sv | 55 +++++
 tb/tb_rv32_exec_datapath.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared RV32I constants: ALU funct3 encodings, the funct7 bit that selects
// SUB/SRA, and the major opcodes used by the CPU control logic.
// No ports (package).
// ----------------------------------------------------------------------------
package rv32_pkg;

    // funct3 values, which are also the ALU operation select
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    // funct7 bit selecting SUB (R-type only) and SRA (both forms)
    localparam int FUNCT7_ALT_BIT = 5;

    // Major opcodes (instruction bits [6:0])
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] JAL    = 7'b1101111;

endpackage

// File: rtl/rv32_exec_datapath_if.sv
// ----------------------------------------------------------------------------
// rv32_exec_datapath_if
// Bundles the register-file and ALU signals of the execution datapath.
//   master : CPU control side (drives addresses, write data, ALU controls)
//   slave  : datapath side (returns read data and ALU result)
// Signals:
//   rs1_addr/rs2_addr/rd_addr [4:0], wr_data [31:0], wr_en,
//   rs1_data/rs2_data [31:0], alu_b [31:0], alu_op [2:0], funct7 [6:0],
//   op_is_reg, alu_result [31:0]
// ----------------------------------------------------------------------------
interface rv32_exec_datapath_if;

    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] wr_data;
    logic        wr_en;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [6:0]  funct7;
    logic        op_is_reg;
    logic [31:0] alu_result;

    modport master (
        output rs1_addr, rs2_addr, rd_addr, wr_data, wr_en,
        output alu_b, alu_op, funct7, op_is_reg,
        input  rs1_data, rs2_data, alu_result
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_addr, wr_data, wr_en,
        input  alu_b, alu_op, funct7, op_is_reg,
        output rs1_data, rs2_data, alu_result
    );

endinterface

// File: rtl/rv32_alu.sv
// ----------------------------------------------------------------------------
// rv32_alu
// Purely combinational RV32I integer ALU.
// Ports:
//   i_a      [31:0] operand A
//   i_b      [31:0] operand B (register or sign-extended immediate)
//   i_op     [2:0]  operation (instruction funct3)
//   i_alt_en        1 = R-type; enables SUB on funct3=000
//   i_funct7 [6:0]  instruction bits [31:25]; only the alt bit is used
//   o_out    [31:0] result
// ----------------------------------------------------------------------------
module rv32_alu
    import rv32_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_op,
    input  logic        i_alt_en,
    input  logic [6:0]  i_funct7,
    output logic [31:0] o_out
);

    logic       w_alt;
    logic [4:0] w_shamt;
    logic       w_unused;

    assign w_alt   = i_funct7[FUNCT7_ALT_BIT];
    assign w_shamt = i_b[4:0];

    // Remaining funct7 bits carry no meaning for the base integer ALU.
    assign w_unused = ^{i_funct7[6], i_funct7[4:0]};

    always_comb begin
        // NOTE: assigning a default before the case keeps every path driven,
        // so no latch is inferred if an arm is ever left incomplete.
        o_out = '0;
        unique case (i_op)
            // SUB only for R-type: ADDI with funct7-looking imm bits must add.
            F3_ADD_SUB: o_out = (i_alt_en && w_alt) ? (i_a - i_b) : (i_a + i_b);
            F3_SLL:     o_out = i_a << w_shamt;
            F3_SLT:     o_out = {31'd0, $signed(i_a) < $signed(i_b)};
            F3_SLTU:    o_out = {31'd0, i_a < i_b};
            F3_XOR:     o_out = i_a ^ i_b;
            // Shift type is chosen by the alt bit in both R and I forms.
            F3_SRL_SRA: o_out = w_alt ? 32'($signed(i_a) >>> w_shamt) : (i_a >> w_shamt);
            F3_OR:      o_out = i_a | i_b;
            F3_AND:     o_out = i_a & i_b;
            default:    o_out = '0;
        endcase
    end

endmodule

// File: rtl/rv32_exec_datapath.sv
// ----------------------------------------------------------------------------
// rv32_exec_datapath
// RV32I execution datapath: 32x32 register file (two combinational read
// ports, one synchronous write port) feeding the ALU. ALU operand A is
// always read port 1. No write-to-read bypass: a read in the same cycle as a
// write to that register returns the old value.
// Ports:
//   clk    rising-edge clock for register writes
//   reset  asynchronous, active-high; clears all registers
//   bus    rv32_exec_datapath_if.slave (register-file and ALU signals)
// ----------------------------------------------------------------------------
module rv32_exec_datapath
    import rv32_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    rv32_exec_datapath_if.slave  bus
);

    logic [31:0] r_regs [32];
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;

    // NOTE: the register array is reset because an asynchronous clear of all
    // registers is part of the architectural contract; this forces flops
    // rather than a RAM macro, which is acceptable at 32 entries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                // NOTE: non-blocking assignment for all sequential state so
                // every flop samples pre-edge values.
                r_regs[i] <= '0;
            end
        end else if (bus.wr_en && (bus.rd_addr != 5'd0)) begin
            r_regs[bus.rd_addr] <= bus.wr_data;
        end
    end

    // x0 is hardwired to zero on the read side as well.
    assign w_rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 : r_regs[bus.rs1_addr];
    assign w_rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 : r_regs[bus.rs2_addr];

    assign bus.rs1_data = w_rs1_data;
    assign bus.rs2_data = w_rs2_data;

    rv32_alu u_alu (
        .i_a      (w_rs1_data),
        .i_b      (bus.alu_b),
        .i_op     (bus.alu_op),
        .i_alt_en (bus.op_is_reg),
        .i_funct7 (bus.funct7),
        .o_out    (bus.alu_result)
    );

endmodule

// File: tb/tb_rv32_exec_datapath.sv
// ----------------------------------------------------------------------------
// tb_rv32_exec_datapath
// Self-checking bench: directed scenarios with fixed expected values, then
// randomized cycles compared against an architectural model (register array
// plus an instruction-level ALU function).
// ----------------------------------------------------------------------------
module tb_rv32_exec_datapath;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_bad;

    rv32_exec_datapath_if bus ();

    rv32_exec_datapath dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural register state
    logic [31:0] model_regs [32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // ALU behaviour written from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [6:0] f7,
                                            input logic is_reg);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            3'd0: return (is_reg && f7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                if (f7[5] && a[31]) return (a >> sh) | ~(32'hFFFF_FFFF >> sh);
                return a >> sh;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    endtask

    task automatic do_write(input logic [4:0] rd, input logic [31:0] data);
        bus.rd_addr = rd;
        bus.wr_data = data;
        bus.wr_en   = 1'b1;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        if (rd != 5'd0) model_regs[rd] = data;
    endtask

    task automatic set_alu(input logic [4:0] rs1, input logic [31:0] b, input logic [2:0] op,
                           input logic [6:0] f7, input logic is_reg);
        bus.rs1_addr  = rs1;
        bus.alu_b     = b;
        bus.alu_op    = op;
        bus.funct7    = f7;
        bus.op_is_reg = is_reg;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_res;
        n_checks = 0;
        n_bad    = 0;
        clear_model();

        reset         = 1'b1;
        bus.rs1_addr  = 5'd3;
        bus.rs2_addr  = 5'd17;
        bus.rd_addr   = 5'd0;
        bus.wr_data   = 32'd0;
        bus.wr_en     = 1'b0;
        bus.alu_b     = 32'd0;
        bus.alu_op    = 3'd0;
        bus.funct7    = 7'd0;
        bus.op_is_reg = 1'b0;
        #2;
        check("reset_rs1", bus.rs1_data, 32'd0);
        check("reset_rs2", bus.rs2_data, 32'd0);
        check("reset_alu", bus.alu_result, 32'd0);

        // Writes are ignored while reset is held
        bus.rd_addr = 5'd3; bus.wr_data = 32'hAAAA_5555; bus.wr_en = 1'b1;
        @(posedge clk); #1;
        check("write_in_reset", bus.rs1_data, 32'd0);
        bus.wr_en = 1'b0;

        // Release mid-cycle; the next edge must write normally
        @(negedge clk);
        reset = 1'b0;
        do_write(5'd5, 32'h0000_1234);
        bus.rs1_addr = 5'd5; #1;
        check("x5_written", bus.rs1_data, 32'h0000_1234);

        // Asynchronous reset between edges clears immediately
        @(negedge clk);
        reset = 1'b1; #1;
        check("async_reset_x5", bus.rs1_data, 32'd0);
        clear_model();
        #1;
        reset = 1'b0;

        // x0 stays zero
        do_write(5'd0, 32'hDEAD_BEEF);
        bus.rs1_addr = 5'd0; #1;
        check("x0_read", bus.rs1_data, 32'd0);

        // Read-during-write returns old value
        bus.rs2_addr = 5'd1;
        bus.rd_addr = 5'd1; bus.wr_data = 32'd7; bus.wr_en = 1'b1;
        #1;
        check("x1_before_edge", bus.rs2_data, 32'd0);
        @(posedge clk); #1;
        bus.wr_en = 1'b0;
        model_regs[1] = 32'd7;
        check("x1_after_edge", bus.rs2_data, 32'd7);

        // ADD/SUB
        do_write(5'd1, 32'd10);
        set_alu(5'd1, 32'd3, 3'b000, 7'h20, 1'b1);
        check("sub", bus.alu_result, 32'd7);
        set_alu(5'd1, 32'd3, 3'b000, 7'h00, 1'b1);
        check("add", bus.alu_result, 32'd13);
        set_alu(5'd1, 32'hFFFF_FFFF, 3'b000, 7'h7F, 1'b0);
        check("addi_neg", bus.alu_result, 32'd9);

        // Compares
        do_write(5'd2, 32'hFFFF_FFFF);
        set_alu(5'd2, 32'd1, 3'b010, 7'h00, 1'b1);
        check("slt_neg", bus.alu_result, 32'd1);
        set_alu(5'd2, 32'd1, 3'b011, 7'h00, 1'b1);
        check("sltu_big", bus.alu_result, 32'd0);
        do_write(5'd3, 32'd5);
        set_alu(5'd3, 32'd5, 3'b010, 7'h00, 1'b1);
        check("slt_equal", bus.alu_result, 32'd0);

        // Shifts (B[31:5] ignored)
        do_write(5'd4, 32'h8000_0000);
        set_alu(5'd4, 32'h24, 3'b101, 7'h20, 1'b1);
        check("sra", bus.alu_result, 32'hF800_0000);
        set_alu(5'd4, 32'h24, 3'b101, 7'h00, 1'b1);
        check("srl", bus.alu_result, 32'h0800_0000);
        set_alu(5'd4, 32'h24, 3'b101, 7'h20, 1'b0);
        check("srai", bus.alu_result, 32'hF800_0000);
        do_write(5'd6, 32'd1);
        set_alu(5'd6, 32'd31, 3'b001, 7'h00, 1'b1);
        check("sll31", bus.alu_result, 32'h8000_0000);

        // Logic
        do_write(5'd7, 32'hF0F0_F0F0);
        set_alu(5'd7, 32'h0FF0_0FF0, 3'b100, 7'h00, 1'b1);
        check("xor", bus.alu_result, 32'hFF00_FF00);
        set_alu(5'd7, 32'h0FF0_0FF0, 3'b110, 7'h00, 1'b1);
        check("or", bus.alu_result, 32'hFFF0_FFF0);
        set_alu(5'd7, 32'h0FF0_0FF0, 3'b111, 7'h00, 1'b1);
        check("and", bus.alu_result, 32'h00F0_00F0);

        // Randomized cycles against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.rs1_addr  = 5'($urandom_range(0, 31));
            bus.rs2_addr  = 5'($urandom_range(0, 31));
            bus.rd_addr   = 5'($urandom_range(0, 31));
            bus.wr_data   = $urandom;
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.alu_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            bus.alu_op    = 3'($urandom_range(0, 7));
            bus.funct7    = 7'($urandom_range(0, 127));
            bus.op_is_reg = 1'($urandom_range(0, 1));

            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1; #1;
                check("rnd_reset_rs1", bus.rs1_data, 32'd0);
                check("rnd_reset_rs2", bus.rs2_data, 32'd0);
                clear_model();
                reset = 1'b0;
            end

            #1;
            check("rnd_rs1", bus.rs1_data, model_regs[bus.rs1_addr]);
            check("rnd_rs2", bus.rs2_data, model_regs[bus.rs2_addr]);
            exp_res = ref_alu(bus.alu_op, model_regs[bus.rs1_addr], bus.alu_b,
                              bus.funct7, bus.op_is_reg);
            check("rnd_alu", bus.alu_result, exp_res);

            @(posedge clk);
            if (bus.wr_en && bus.rd_addr != 5'd0) model_regs[bus.rd_addr] = bus.wr_data;
            #1;
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
